fetch_unit: RTL and testbench

Instruction fetch stage that produces the instruction stream consumed by the opcode decoder and control unit. It owns the fetch PC and issues word requests to instruction memory over a valid/ready request channel with an in-order response channel. Returned words sit in a 2-entry buffer and are presented to decode with a valid/ready handshake. Branch, jal and jalr redirects from execute flush the buffer and discard stale in-flight responses.

---
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word requests to instruction
// memory under a 2-slot credit scheme and buffers returned words for decode.
module fetch_unit #(
   parameter logic [31:0]    RESET_PC = 32'h0000_0000,
   localparam int unsigned   XLEN     = 32,
   localparam int unsigned   OPW      = 7
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst_data,
   output logic [XLEN-1:0] inst_pc,
   output logic [OPW-1:0]  inst_opcode
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] word;
   } fetch_entry_t;

   logic [XLEN-1:0] pc_q, pc_d;
   logic [1:0]      inflight_q, inflight_d;
   logic [1:0]      drop_q, drop_d;
   logic [1:0]      count_q, count_d;
   logic            rd_ptr_q, rd_ptr_d;
   fetch_entry_t    fifo_q [2];
   fetch_entry_t    fifo_d [2];
   logic [XLEN-1:0] rq_pc_q [2];
   logic [XLEN-1:0] rq_pc_d [2];
   logic            rq_wr_q, rq_wr_d;
   logic            rq_rd_q, rq_rd_d;

   logic            pop_c;
   logic            accept_c;
   logic            push_c;
   logic            wr_idx_c;
   logic [2:0]      occ_c;
   logic            redirect_lsb_unused;

   assign inst_valid  = (count_q != 2'd0);
   assign inst_data   = fifo_q[rd_ptr_q].word;
   assign inst_pc     = fifo_q[rd_ptr_q].pc;
   assign inst_opcode = inst_data[OPW-1:0];

   // Credit check: requests in flight plus buffered words never exceed two slots.
   assign pop_c          = inst_valid & inst_ready;
   assign occ_c          = 3'(inflight_q) + 3'(count_q) - 3'(pop_c);
   assign imem_req_valid = ~rst & ~redirect_valid & (occ_c < 3'd2);
   assign accept_c       = imem_req_valid & imem_req_ready;
   assign imem_addr      = {pc_q[XLEN-1:2], 2'b00};

   assign redirect_lsb_unused = ^redirect_pc[1:0];

   always_comb begin
      pc_d       = pc_q;
      inflight_d = inflight_q;
      drop_d     = drop_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      fifo_d     = fifo_q;
      rq_pc_d    = rq_pc_q;
      rq_wr_d    = rq_wr_q;
      rq_rd_d    = rq_rd_q;
      push_c     = 1'b0;
      wr_idx_c   = rd_ptr_q ^ count_q[0];

      // Every response retires its request PC, whether kept or discarded.
      if (imem_rsp_valid) begin
         rq_rd_d = ~rq_rd_q;
      end

      if (redirect_valid) begin
         // Squash the buffer and mark every unanswered request as stale.
         pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
         count_d    = 2'd0;
         inflight_d = inflight_q - 2'(imem_rsp_valid);
         drop_d     = inflight_q - 2'(imem_rsp_valid);
      end else begin
         if (accept_c) begin
            pc_d             = pc_q + XLEN'(4);
            rq_pc_d[rq_wr_q] = pc_q;
            rq_wr_d          = ~rq_wr_q;
         end
         inflight_d = inflight_q + 2'(accept_c) - 2'(imem_rsp_valid);
         if (imem_rsp_valid) begin
            if (drop_q != 2'd0) begin
               drop_d = drop_q - 2'd1;
            end else begin
               push_c = 1'b1;
            end
         end
         if (push_c) begin
            fifo_d[wr_idx_c] = '{pc: rq_pc_q[rq_rd_q], word: imem_rsp_data};
         end
         if (pop_c) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = count_q + 2'(push_c) - 2'(pop_c);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         inflight_q <= 2'd0;
         drop_q     <= 2'd0;
         count_q    <= 2'd0;
         rd_ptr_q   <= 1'b0;
         fifo_q     <= '{default: '0};
         rq_pc_q    <= '{default: '0};
         rq_wr_q    <= 1'b0;
         rq_rd_q    <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         fifo_q     <= fifo_d;
         rq_pc_q    <= rq_pc_d;
         rq_wr_q    <= rq_wr_d;
         rq_rd_q    <= rq_rd_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus pushes expected {pc, word}
// pairs; a monitor pops and compares on every decode handshake.
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic [6:0]  inst_opcode;

   fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_opcode    (inst_opcode)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   exp_t  exp_q [$];
   pend_t pend_q [$];
   int    checks = 0;
   int    errors = 0;
   int    pops   = 0;
   int    lat    = 1;
   int    mcyc   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0000_0013;
         32'h0000_0004: return 32'h00A0_0093;
         32'h0000_0008: return 32'h0000_A103;
         32'h0000_000C: return 32'h0011_2023;
         default:       return 32'hC0DE_0000 | {16'h0000, a[15:0]};
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input logic [31:0] pc, input logic [31:0] word);
      exp_t e;
      e.pc   = pc;
      e.word = word;
      exp_q.push_back(e);
   endtask

   task automatic wait_pops(input int target);
      int b;
      b = 0;
      while (pops < target && b < 60) begin
         @(negedge clk);
         b++;
      end
      chk("pop_count", 32'(pops), 32'(target));
   endtask

   task automatic do_redirect(input logic [31:0] tgt);
      redirect_valid = 1'b1;
      redirect_pc    = tgt;
      #3;
      chk("redirect_req_valid", 32'(imem_req_valid), 32'd0);
   endtask

   // Instruction memory: in-order responses 'lat' cycles after acceptance.
   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      forever begin
         @(negedge clk);
         mcyc++;
         if (pend_q.size() > 0 && pend_q[0].due <= mcyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_q[0].addr);
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
         end
         #1;
         if (rst) begin
            pend_q.delete();
         end else begin
            if (imem_rsp_valid) void'(pend_q.pop_front());
            if (imem_req_valid && imem_req_ready) begin
               pend_t p;
               p.addr = imem_addr;
               p.due  = mcyc + lat;
               pend_q.push_back(p);
            end
         end
      end
   end

   // Monitor: compare each accepted instruction against the scoreboard head.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!rst && !redirect_valid && inst_valid && inst_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_inst: got pc 0x%08h data 0x%08h expected none", inst_pc, inst_data);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("inst_pc", inst_pc, e.pc);
               chk("inst_data", inst_data, e.word);
               chk("inst_opcode", 32'(inst_opcode), 32'(e.word[6:0]));
            end
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b1;
      imem_req_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      inst_ready     = 1'b0;

      // Reset held three cycles
      repeat (3) @(negedge clk);
      #3;
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst_data", inst_data, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h0);
      chk("rst_opcode", 32'(inst_opcode), 32'd0);

      // Streaming, zero-wait memory
      @(negedge clk);
      rst        = 1'b0;
      inst_ready = 1'b1;
      push_exp(32'h0, 32'h0000_0013);
      push_exp(32'h4, 32'h00A0_0093);
      push_exp(32'h8, 32'h0000_A103);
      push_exp(32'hC, 32'h0011_2023);
      #3;
      chk("first_req_valid", 32'(imem_req_valid), 32'd1);
      chk("first_req_addr", imem_addr, 32'h0);
      @(negedge clk);
      #3;
      chk("c1_inst_valid", 32'(inst_valid), 32'd0);
      @(negedge clk);
      #3;
      chk("c2_inst_valid", 32'(inst_valid), 32'd1);
      wait_pops(4);
      do_redirect(32'h0);

      // Backpressure for five cycles
      @(negedge clk);
      redirect_valid = 1'b0;
      inst_ready     = 1'b0;
      push_exp(32'h0, 32'h0000_0013);
      push_exp(32'h4, 32'h00A0_0093);
      push_exp(32'h8, 32'h0000_A103);
      push_exp(32'hC, 32'h0011_2023);
      #3;
      chk("bp_req_valid", 32'(imem_req_valid), 32'd1);
      chk("bp_req_addr", imem_addr, 32'h0);
      @(negedge clk);
      @(negedge clk);
      #3;
      chk("bp_credit_block", 32'(imem_req_valid), 32'd0);
      @(negedge clk);
      #3;
      chk("bp_full_req_valid", 32'(imem_req_valid), 32'd0);
      chk("bp_full_inst_valid", 32'(inst_valid), 32'd1);
      chk("bp_hold_data", inst_data, 32'h0000_0013);
      chk("bp_hold_pc", inst_pc, 32'h0);
      @(negedge clk);
      #3;
      chk("bp_hold_data2", inst_data, 32'h0000_0013);
      chk("bp_full_req_valid2", 32'(imem_req_valid), 32'd0);
      @(negedge clk);
      inst_ready = 1'b1;
      wait_pops(8);
      do_redirect(32'h0);

      // Memory stall with pc at 0x8
      @(negedge clk);
      redirect_valid = 1'b0;
      push_exp(32'h0, 32'h0000_0013);
      push_exp(32'h4, 32'h00A0_0093);
      push_exp(32'h8, 32'h0000_A103);
      push_exp(32'hC, 32'h0011_2023);
      #3;
      chk("stall_first_addr", imem_addr, 32'h0);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         imem_req_ready = 1'b0;
         #3;
         chk("stall_addr_hold", imem_addr, 32'h8);
         chk("stall_req_valid", 32'(imem_req_valid), 32'd1);
      end
      @(negedge clk);
      imem_req_ready = 1'b1;
      #3;
      chk("stall_release_addr", imem_addr, 32'h8);
      @(negedge clk);
      #3;
      chk("stall_advance_addr", imem_addr, 32'hC);
      wait_pops(12);

      // Redirect with two stale requests in flight, latency 3
      lat = 3;
      do_redirect(32'h40);
      @(negedge clk);
      redirect_valid = 1'b0;
      #3;
      chk("r1_addr", imem_addr, 32'h40);
      @(negedge clk);
      #3;
      chk("r1_addr2", imem_addr, 32'h44);
      chk("r1_req_valid2", 32'(imem_req_valid), 32'd1);
      @(negedge clk);
      do_redirect(32'h103);
      @(negedge clk);
      redirect_valid = 1'b0;
      #3;
      chk("r2_blocked", 32'(imem_req_valid), 32'd0);
      chk("r2_target_addr", imem_addr, 32'h100);
      @(negedge clk);
      #3;
      chk("r2_req_valid", 32'(imem_req_valid), 32'd1);
      chk("r2_req_addr", imem_addr, 32'h100);
      @(negedge clk);
      #3;
      chk("r2_req_addr2", imem_addr, 32'h104);
      @(negedge clk);
      @(negedge clk);
      #3;
      chk("r2_no_stale_valid", 32'(inst_valid), 32'd0);
      @(negedge clk);
      inst_ready = 1'b0;
      #3;
      chk("r2_inst_valid", 32'(inst_valid), 32'd1);
      chk("r2_inst_pc", inst_pc, 32'h100);
      @(negedge clk);
      #3;
      chk("r2_inst_data", inst_data, 32'hC0DE_0100);
      chk("r2_full_req_valid", 32'(imem_req_valid), 32'd0);

      // Reset mid-stream with a full buffer
      @(negedge clk);
      rst = 1'b1;
      #3;
      chk("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
      @(negedge clk);
      #3;
      chk("mid_rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("mid_rst_addr", imem_addr, 32'h0);
      chk("mid_rst_inst_pc", inst_pc, 32'h0);
      chk("mid_rst_inst_data", inst_data, 32'h0);
      chk("mid_rst_req_valid2", 32'(imem_req_valid), 32'd0);
      @(negedge clk);
      rst        = 1'b0;
      lat        = 1;
      inst_ready = 1'b1;
      push_exp(32'h0, 32'h0000_0013);
      push_exp(32'h4, 32'h00A0_0093);
      push_exp(32'h8, 32'h0000_A103);
      push_exp(32'hC, 32'h0011_2023);
      #3;
      chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
      chk("post_rst_addr", imem_addr, 32'h0);
      wait_pops(16);
      inst_ready = 1'b0;
      do_redirect(32'h200);
      @(negedge clk);
      redirect_valid = 1'b0;
      repeat (6) @(negedge clk);
      #3;
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      chk("no_extra_pops", 32'(pops), 32'd16);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
